// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields in,
// registered EX fields and hazard controls out.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [4:0]       id_dest;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [31:0]      id_qa;
  logic [31:0]      id_qb;
  logic [31:0]      id_imm;
  logic             id_wreg;
  logic             id_m2reg;
  logic             id_wmem;
  logic             id_aluimm;
  logic             id_shift;
  logic             id_jal;
  logic [3:0]       id_aluc;
  logic             ex_valid;
  logic [4:0]       ex_dest;
  logic [31:0]      ex_qa;
  logic [31:0]      ex_qb;
  logic [31:0]      ex_imm;
  logic [3:0]       ex_aluc;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic             ex_wmem;
  logic             ex_aluimm;
  logic             ex_shift;
  logic             ex_jal;
  logic             stall;
  logic             pc_we;
  logic             ifid_we;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output hold, flush, id_valid, id_instr,
    output id_dest, id_uses_rs, id_uses_rt,
    output id_qa, id_qb, id_imm,
    output id_wreg, id_m2reg, id_wmem,
    output id_aluimm, id_shift, id_jal,
    output id_aluc,
    input  ex_valid, ex_dest,
    input  ex_qa, ex_qb, ex_imm, ex_aluc,
    input  ex_wreg, ex_m2reg, ex_wmem,
    input  ex_aluimm, ex_shift, ex_jal,
    input  stall, pc_we, ifid_we,
    input  stall_count
  );

  modport slave (
    input  hold, flush, id_valid, id_instr,
    input  id_dest, id_uses_rs, id_uses_rt,
    input  id_qa, id_qb, id_imm,
    input  id_wreg, id_m2reg, id_wmem,
    input  id_aluimm, id_shift, id_jal,
    input  id_aluc,
    output ex_valid, ex_dest,
    output ex_qa, ex_qb, ex_imm, ex_aluc,
    output ex_wreg, ex_m2reg, ex_wmem,
    output ex_aluimm, ex_shift, ex_jal,
    output stall, pc_we, ifid_we,
    output stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard
// detection, bubble insertion and stall counter.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [31:0] imm;
    logic [3:0]  aluc;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic        aluimm;
    logic        shift;
    logic        jal;
  } ex_t;

  ex_t              ex_q;
  ex_t              ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic             rs_hit;
  logic             rt_hit;
  logic             ld_in_ex;
  logic             haz;
  logic             stall;

  assign rs = bus.id_instr[25:21];
  assign rt = bus.id_instr[20:16];

  // Load in EX whose nonzero target is read in ID
  always_comb begin
    ld_in_ex = ex_q.valid & ex_q.m2reg &
               (ex_q.dest != 5'd0);
    rs_hit   = bus.id_uses_rs & (ex_q.dest == rs);
    rt_hit   = bus.id_uses_rt & (ex_q.dest == rt);
    haz      = ld_in_ex & bus.id_valid &
               (rs_hit | rt_hit);
    stall    = haz & ~bus.flush & ~bus.hold;
  end

  // Next EX contents: hold, bubble or capture
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.hold) begin
      ex_d = ex_q;
    end else if (bus.flush | stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid  = bus.id_valid;
      ex_d.dest   = bus.id_dest;
      ex_d.qa     = bus.id_qa;
      ex_d.qb     = bus.id_qb;
      ex_d.imm    = bus.id_imm;
      ex_d.aluc   = bus.id_aluc;
      ex_d.aluimm = bus.id_aluimm;
      ex_d.shift  = bus.id_shift;
      ex_d.wreg   = bus.id_wreg  & bus.id_valid;
      ex_d.m2reg  = bus.id_m2reg & bus.id_valid;
      ex_d.wmem   = bus.id_wmem  & bus.id_valid;
      ex_d.jal    = bus.id_jal   & bus.id_valid;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_dest     = ex_q.dest;
  assign bus.ex_qa       = ex_q.qa;
  assign bus.ex_qb       = ex_q.qb;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_aluc     = ex_q.aluc;
  assign bus.ex_wreg     = ex_q.wreg;
  assign bus.ex_m2reg    = ex_q.m2reg;
  assign bus.ex_wmem     = ex_q.wmem;
  assign bus.ex_aluimm   = ex_q.aluimm;
  assign bus.ex_shift    = ex_q.shift;
  assign bus.ex_jal      = ex_q.jal;
  assign bus.stall       = stall;
  assign bus.pc_we       = ~bus.hold & ~stall;
  assign bus.ifid_we     = ~bus.hold & ~stall;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed table, hand
// sequences and random stimulus vs a model.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hold, flush, idv;
  logic [4:0]  rs, rt, dest;
  logic        urs, urt;
  logic [31:0] qa, qb, imm;
  logic        wreg, m2reg, wmem, aluimm, shift, jal;
  logic [3:0]  aluc;

  id_ex_stage_if #(.CNT_W(16)) b0 ();
  id_ex_stage_if #(.CNT_W(2))  b1 ();

  id_ex_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(b0.slave));
  id_ex_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  assign b0.hold = hold;        assign b1.hold = hold;
  assign b0.flush = flush;      assign b1.flush = flush;
  assign b0.id_valid = idv;     assign b1.id_valid = idv;
  assign b0.id_instr = {6'd0, rs, rt, 16'h0};
  assign b1.id_instr = {6'd0, rs, rt, 16'h0};
  assign b0.id_dest = dest;     assign b1.id_dest = dest;
  assign b0.id_uses_rs = urs;   assign b1.id_uses_rs = urs;
  assign b0.id_uses_rt = urt;   assign b1.id_uses_rt = urt;
  assign b0.id_qa = qa;         assign b1.id_qa = qa;
  assign b0.id_qb = qb;         assign b1.id_qb = qb;
  assign b0.id_imm = imm;       assign b1.id_imm = imm;
  assign b0.id_wreg = wreg;     assign b1.id_wreg = wreg;
  assign b0.id_m2reg = m2reg;   assign b1.id_m2reg = m2reg;
  assign b0.id_wmem = wmem;     assign b1.id_wmem = wmem;
  assign b0.id_aluimm = aluimm; assign b1.id_aluimm = aluimm;
  assign b0.id_shift = shift;   assign b1.id_shift = shift;
  assign b0.id_jal = jal;       assign b1.id_jal = jal;
  assign b0.id_aluc = aluc;     assign b1.id_aluc = aluc;

  int total = 0;
  int bad = 0;

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t",
               n, a, e, $time);
    end
  endtask

  // Reference model: what EX should hold
  logic        m_v, m_wreg, m_m2reg, m_wmem;
  logic        m_aluimm, m_shift, m_jal;
  logic [4:0]  m_dest;
  logic [31:0] m_qa, m_qb, m_imm;
  logic [3:0]  m_aluc;
  int          m_c16, m_c2;

  function automatic bit m_stall();
    bit reads;
    bit is_load;
    is_load = m_v && m_m2reg && (m_dest != 0);
    reads = (urs && rs == m_dest) ||
            (urt && rt == m_dest);
    return is_load && idv && reads && !flush && !hold;
  endfunction

  task automatic model_check();
    bit st;
    st = m_stall();
    chk("stall", b0.stall, st);
    chk("pc_we", b0.pc_we, !hold && !st);
    chk("ifid_we", b0.ifid_we, !hold && !st);
    chk("ex_valid", b0.ex_valid, m_v);
    chk("ex_dest", b0.ex_dest, m_dest);
    chk("ex_qa", b0.ex_qa, m_qa);
    chk("ex_qb", b0.ex_qb, m_qb);
    chk("ex_imm", b0.ex_imm, m_imm);
    chk("ex_aluc", b0.ex_aluc, m_aluc);
    chk("ex_flags",
        {b0.ex_wreg, b0.ex_m2reg, b0.ex_wmem,
         b0.ex_aluimm, b0.ex_shift, b0.ex_jal},
        {m_wreg, m_m2reg, m_wmem,
         m_aluimm, m_shift, m_jal});
    chk("cnt16", b0.stall_count, m_c16);
    chk("stall2", b1.stall, st);
    chk("cnt2", b1.stall_count, m_c2);
  endtask

  task automatic model_edge();
    bit st;
    st = m_stall();
    if (rst) begin
      {m_v, m_wreg, m_m2reg, m_wmem} = '0;
      {m_aluimm, m_shift, m_jal} = '0;
      m_dest = 0; m_qa = 0; m_qb = 0;
      m_imm = 0; m_aluc = 0;
      m_c16 = 0; m_c2 = 0;
    end else if (!hold) begin
      if (st) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c2 < 3) m_c2++;
      end
      if (flush || st) begin
        {m_v, m_wreg, m_m2reg, m_wmem} = '0;
        {m_aluimm, m_shift, m_jal} = '0;
        m_dest = 0; m_qa = 0; m_qb = 0;
        m_imm = 0; m_aluc = 0;
      end else begin
        m_v = idv;
        m_dest = dest;
        m_qa = qa; m_qb = qb; m_imm = imm;
        m_aluc = aluc;
        m_aluimm = aluimm; m_shift = shift;
        m_wreg = idv && wreg;
        m_m2reg = idv && m2reg;
        m_wmem = idv && wmem;
        m_jal = idv && jal;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit          rst, hold, flush, idv;
    logic [4:0]  rs, rt;
    bit          urs, urt;
    logic [4:0]  dest;
    logic [31:0] qa;
    bit          wreg, m2reg;
    bit          e_stall, e_pcwe, e_exv;
    logic [4:0]  e_dest;
    bit          e_wreg;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(
    bit r, bit h, bit f, bit v,
    logic [4:0] s, logic [4:0] t, bit us, bit ut,
    logic [4:0] d, logic [31:0] a, bit w, bit m,
    bit es, bit ep, bit ev, logic [4:0] ed,
    bit ew, int ec);
    vec_t x;
    x.rst = r; x.hold = h; x.flush = f; x.idv = v;
    x.rs = s; x.rt = t; x.urs = us; x.urt = ut;
    x.dest = d; x.qa = a; x.wreg = w; x.m2reg = m;
    x.e_stall = es; x.e_pcwe = ep; x.e_exv = ev;
    x.e_dest = ed; x.e_wreg = ew; x.e_cnt = ec;
    return x;
  endfunction

  task automatic set_in(
    bit r, bit h, bit f, bit v,
    logic [4:0] s, logic [4:0] t, bit us, bit ut,
    logic [4:0] d, logic [31:0] a, bit w, bit m);
    rst = r; hold = h; flush = f; idv = v;
    rs = s; rt = t; urs = us; urt = ut;
    dest = d; qa = a; wreg = w; m2reg = m;
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = mk(0,0,0,1, 1,2,1,1, 8,32'h1234,1,0,
                 0,1,0,0,0,0);
    tbl[1]  = mk(0,0,0,1, 8,0,1,0, 9,32'h1,1,1,
                 0,1,1,8,1,0);
    tbl[2]  = mk(0,0,0,1, 3,9,1,1, 10,32'h2,1,0,
                 1,0,1,9,1,0);
    tbl[3]  = mk(0,0,0,1, 3,9,1,1, 10,32'h2,1,0,
                 0,1,0,0,0,1);
    tbl[4]  = mk(0,0,0,1, 0,0,1,0, 0,32'h3,1,1,
                 0,1,1,10,1,1);
    tbl[5]  = mk(0,0,0,1, 0,0,1,0, 11,32'h4,1,0,
                 0,1,1,0,1,1);
    tbl[6]  = mk(0,0,0,1, 11,0,1,0, 12,32'h5,1,1,
                 0,1,1,11,1,1);
    tbl[7]  = mk(0,0,1,1, 0,12,0,1, 20,32'h6,1,0,
                 0,1,1,12,1,1);
    tbl[8]  = mk(0,0,0,1, 12,12,0,0, 13,32'h7,1,1,
                 0,1,0,0,0,1);
    tbl[9]  = mk(0,1,0,1, 13,0,1,0, 14,32'h8,1,0,
                 0,0,1,13,1,1);
    tbl[10] = mk(0,1,0,1, 13,0,1,0, 20,32'h5555,0,1,
                 0,0,1,13,1,1);
    tbl[11] = mk(0,1,0,0, 13,0,1,0, 21,32'h9,1,1,
                 0,0,1,13,1,1);
    tbl[12] = mk(0,0,0,1, 13,0,1,0, 14,32'ha,1,0,
                 1,0,1,13,1,1);
    tbl[13] = mk(0,0,0,1, 13,0,1,0, 14,32'ha,1,0,
                 0,1,0,0,0,2);
    tbl[14] = mk(0,0,0,1, 0,0,0,0, 15,32'hb,1,1,
                 0,1,1,14,1,2);
    tbl[15] = mk(1,0,0,1, 0,15,0,1, 16,32'hc,1,0,
                 1,0,1,15,1,2);
    tbl[16] = mk(0,0,0,0, 0,15,0,1, 16,32'hd,1,0,
                 0,1,0,0,0,0);
    tbl[17] = mk(0,0,0,1, 0,0,0,0, 17,32'he,0,0,
                 0,1,0,16,0,0);

    {wmem, aluimm, shift, jal} = '0;
    qb = 0; imm = 0; aluc = 0;
    set_in(1,0,0,0, 0,0,0,0, 0,0,0,0);
    {m_v, m_wreg, m_m2reg, m_wmem} = '0;
    {m_aluimm, m_shift, m_jal} = '0;
    m_dest = 0; m_qa = 0; m_qb = 0;
    m_imm = 0; m_aluc = 0; m_c16 = 0; m_c2 = 0;
    @(posedge clk);
    model_edge();
    #1;

    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].rst, tbl[i].hold, tbl[i].flush,
             tbl[i].idv, tbl[i].rs, tbl[i].rt,
             tbl[i].urs, tbl[i].urt, tbl[i].dest,
             tbl[i].qa, tbl[i].wreg, tbl[i].m2reg);
      qb = 32'hb000 + i;
      imm = 32'hc000 + i;
      aluc = 4'(i);
      aluimm = i[0];
      shift = i[1];
      @(negedge clk);
      chk($sformatf("t%0d_stall", i),
          b0.stall, tbl[i].e_stall);
      chk($sformatf("t%0d_pc_we", i),
          b0.pc_we, tbl[i].e_pcwe);
      chk($sformatf("t%0d_ifid_we", i),
          b0.ifid_we, tbl[i].e_pcwe);
      chk($sformatf("t%0d_ex_valid", i),
          b0.ex_valid, tbl[i].e_exv);
      chk($sformatf("t%0d_ex_dest", i),
          b0.ex_dest, tbl[i].e_dest);
      chk($sformatf("t%0d_ex_wreg", i),
          b0.ex_wreg, tbl[i].e_wreg);
      chk($sformatf("t%0d_cnt", i),
          b0.stall_count, tbl[i].e_cnt);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    // five load-use stalls saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      set_in(0,0,0,1, 0,0,0,0, 5,32'h77,1,1);
      cycle();
      set_in(0,0,0,1, 5,0,1,0, 6,32'h88,1,0);
      cycle();
    end
    @(negedge clk);
    chk("sat_cnt2", b1.stall_count, 32'd3);
    chk("sat_cnt16", b0.stall_count, 32'd5);
    @(posedge clk);
    model_edge();
    #1;

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom % 50) == 0;
      hold = ($urandom % 6) == 0;
      flush = ($urandom % 8) == 0;
      idv = ($urandom % 5) != 0;
      rs = 5'($urandom % 4);
      rt = 5'($urandom % 4);
      urs = 1'($urandom);
      urt = 1'($urandom);
      dest = 5'($urandom % 4);
      qa = $urandom; qb = $urandom; imm = $urandom;
      aluc = 4'($urandom);
      wreg = 1'($urandom);
      m2reg = 1'($urandom);
      wmem = 1'($urandom);
      aluimm = 1'($urandom);
      shift = 1'($urandom);
      jal = 1'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register with integrated load-use hazard detection for the 5-stage pipelined MIPS core. Sits directly downstream of the decode stage's destination-register select (`rt` vs `rd`). Captures the decoded instruction, operands, destination register number and control bits each cycle. Inserts a one-cycle bubble and freezes PC / IF-ID when the instruction in EX is a load whose destination the instruction in ID reads.

## Interface
Parameters:
- `CNT_W`, 16: width of the saturating stall-event counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-high reset
- `hold`  in  1  global freeze (memory wait); ID/EX keeps contents
- `flush`  in  1  branch/jump taken; ID instruction is discarded
- `id_valid`  in  1  ID stage holds a real instruction
- `id_instr`  in  32  instruction word; rs = [25:21], rt = [20:16]
- `id_dest`  in  5  destination register number from decode mux
- `id_uses_rs`, `id_uses_rt`  in  1 each  ID instruction reads rs / rt
- `id_qa`, `id_qb`, `id_imm`  in  32 each  register operands, sign-extended immediate
- `id_wreg`, `id_m2reg`, `id_wmem`, `id_aluimm`, `id_shift`, `id_jal`  in  1 each  control bits
- `id_aluc`  in  4  ALU control
- `ex_valid`  out  1  EX holds a real instruction
- `ex_dest`  out  5; `ex_qa`, `ex_qb`, `ex_imm`  out  32; `ex_aluc`  out  4
- `ex_wreg`, `ex_m2reg`, `ex_wmem`, `ex_aluimm`, `ex_shift`, `ex_jal`  out  1 each
- `stall`  out  1  combinational load-use stall indicator
- `pc_we`, `ifid_we`  out  1 each  write enables for PC and IF/ID register
- `stall_count`  out  CNT_W  saturating count of load-use stall cycles

## Operation
- Hazard: `haz = ex_valid & ex_m2reg & (ex_dest != 0) & id_valid & ((id_uses_rs & ex_dest == id_instr[25:21]) | (id_uses_rt & ex_dest == id_instr[20:16]))`.
- `stall = haz & ~flush & ~hold`. `pc_we = ifid_we = ~hold & ~stall`.
- Register update priority on rising edge:
  1. `rst`: all ex_* outputs 0, `ex_valid` 0, `stall_count` 0.
  2. `hold`: all ex_* registers keep their values; counter unchanged.
  3. `flush` or `stall`: load a bubble. `ex_valid`, `ex_wreg`, `ex_m2reg`, `ex_wmem` and `ex_jal` are 0. The datapath fields (`ex_dest`, `ex_qa`, `ex_qb`, `ex_imm`, `ex_aluc`, `ex_aluimm`, `ex_shift`) are 0.
  4. Otherwise, capture all id_* fields. `ex_valid <= id_valid`. When `id_valid` is 0, the write-enable controls (`wreg`, `m2reg`, `wmem`, `jal`) are forced to 0.
- `stall_count` increments by 1 on each edge where `stall` is 1 and not in reset. It saturates at all-ones and does not wrap.
- Register $0 as a destination never causes a hazard.
- A non-load EX instruction (`ex_m2reg` = 0) never causes a stall; forwarding handles it.

## Timing
- Latency: ID to EX is 1 cycle.
- `stall`, `pc_we` and `ifid_we` are combinational from current-cycle inputs and the ex_* registers. There is no registered delay.
- A load-use stall lasts exactly 1 cycle. The bubble clears `ex_m2reg`, so `haz` is 0 on the next cycle. The held ID instruction then advances.
- `flush` together with `haz`: `flush` wins. `stall` is 0, a bubble is loaded, and the counter does not increment.
- `hold` together with `haz`: `stall` is 0 and `pc_we` is 0. The hazard re-evaluates once `hold` drops.
- `rst` asserted mid-stall: ex_* outputs are 0 on the next edge and `stall` drops that cycle.
- While `rst` is high, ex_* are 0 after the edge, so `stall` is 0.

## Test plan
- Pass-through: `id_valid`=1, `id_dest`=5'd8, `id_qa`=32'h1234, `id_wreg`=1, no hazard. Next cycle: `ex_dest`=8, `ex_qa`=32'h1234, `ex_wreg`=1, `ex_valid`=1, and `pc_we`=1.
- Load-use on rt: EX holds `lw` with `ex_dest`=9 and `ex_m2reg`=1. ID holds `add` with rt=9 and `id_uses_rt`=1. That cycle: `stall`=1, `pc_we`=0, `ifid_we`=0. Next cycle: EX is a bubble (`ex_valid`=0, `ex_wreg`=0), `stall`=0, and `stall_count`=1. The cycle after, the `add` is in EX.
- $0 and non-load: `lw` with `ex_dest`=0 and ID reading $0 gives `stall`=0. An ALU op in EX with `ex_dest`=9 and ID reading $9 gives `stall`=0.
- Flush priority: hazard condition true with `flush`=1. `stall`=0, next-cycle `ex_valid`=0, and `stall_count` unchanged.
- Hold: with `hold`=1 for 3 cycles and varying id_* inputs, ex_* stay constant and `pc_we`=0. After release, the pending hazard produces `stall`=1 for exactly 1 cycle.
- Reset and saturation: `rst` mid-stall gives all outputs 0 after one edge. With `CNT_W`=2, forcing 5 stall cycles gives `stall_count`=3.
